// File: rtl/stack_pkg.sv
// Shared encodings for the call/data stack controller: opcodes, error codes,
// FSM states and default stack bounds.
package stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH = 2'd0,
        OP_POP  = 2'd1,
        OP_CALL = 2'd2,
        OP_RET  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10
    } err_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_UPD  = 2'd2
    } state_t;

    localparam logic [7:0] STACK_TOP_DEF   = 8'hF0;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'hC0;

    // PUSH and CALL write below SP; POP and RET read at SP.
    function automatic logic is_write(input op_t op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_controller.sv
// Stack controller: sequences one memory transfer per command, then strobes
// the external stack pointer and reports POP data / PC loads.
module stack_controller
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_TOP   = STACK_TOP_DEF,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_data,
    input  logic [7:0]  cmd_target,
    input  logic [7:0]  SP,
    output logic        inr_SP,
    output logic        dcr_SP,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        pc_load_en,
    output logic [7:0]  pc_load,
    output logic [1:0]  stack_err
);

    state_t     state;
    op_t        op_q;
    logic [7:0] target_q;
    op_t        op_in;
    logic       wr_in;

    assign op_in = op_t'(cmd_op);
    assign wr_in = is_write(op_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cmd_ready  <= 1'b1;
            op_q       <= OP_PUSH;
            target_q   <= 8'h00;
            inr_SP     <= 1'b0;
            dcr_SP     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 16'h0000;
            rsp_valid  <= 1'b0;
            rsp_data   <= 16'h0000;
            pc_load_en <= 1'b0;
            pc_load    <= 8'h00;
            stack_err  <= ERR_NONE;
        end else begin
            inr_SP     <= 1'b0;
            dcr_SP     <= 1'b0;
            rsp_valid  <= 1'b0;
            pc_load_en <= 1'b0;
            stack_err  <= ERR_NONE;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        if (wr_in && (SP == STACK_LIMIT)) begin
                            stack_err <= ERR_OVERFLOW;
                        end else if (!wr_in && (SP == STACK_TOP)) begin
                            stack_err <= ERR_UNDERFLOW;
                        end else begin
                            state     <= ST_MEM;
                            cmd_ready <= 1'b0;
                            op_q      <= op_in;
                            target_q  <= cmd_target;
                            mem_req   <= 1'b1;
                            mem_we    <= wr_in;
                            mem_addr  <= wr_in ? (SP - 8'd1) : SP;
                            mem_wdata <= (op_in == OP_CALL) ? {8'h00, cmd_data[7:0]} : cmd_data;
                        end
                    end
                end
                // Strobes are registered on the ack edge so they are high during UPD.
                ST_MEM: begin
                    if (mem_ack) begin
                        state   <= ST_UPD;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        case (op_q)
                            OP_PUSH: dcr_SP <= 1'b1;
                            OP_POP: begin
                                inr_SP    <= 1'b1;
                                rsp_valid <= 1'b1;
                                rsp_data  <= mem_rdata;
                            end
                            OP_CALL: begin
                                dcr_SP     <= 1'b1;
                                pc_load_en <= 1'b1;
                                pc_load    <= target_q;
                            end
                            OP_RET: begin
                                inr_SP     <= 1'b1;
                                pc_load_en <= 1'b1;
                                pc_load    <= mem_rdata[7:0];
                            end
                            default: ;
                        endcase
                    end
                end
                ST_UPD: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller with a stack pointer model and a memory model
// whose acknowledge delay is programmable per command.
module tb_stack_controller;
    import stack_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_data = 16'h0000;
    logic [7:0]  cmd_target = 8'h00;
    logic [7:0]  sp;
    logic        inr_SP, dcr_SP;
    logic        mem_req, mem_we, mem_ack;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        pc_load_en;
    logic [7:0]  pc_load;
    logic [1:0]  stack_err;

    logic [15:0] mem [256];
    int          ack_delay = 0;
    int          ack_cnt = 0;
    logic        spur_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_controller #(.STACK_TOP(8'hF0), .STACK_LIMIT(8'hC0)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_data(cmd_data), .cmd_target(cmd_target), .SP(sp),
        .inr_SP(inr_SP), .dcr_SP(dcr_SP),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .pc_load_en(pc_load_en), .pc_load(pc_load), .stack_err(stack_err)
    );

    // Stack pointer block: reset to top, one step per strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                   sp <= 8'hF0;
        else if (inr_SP && !dcr_SP)   sp <= sp + 8'd1;
        else if (dcr_SP && !inr_SP)   sp <= sp - 8'd1;
    end

    assign mem_ack   = (mem_req && (ack_cnt >= ack_delay)) || spur_ack;
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (!mem_req || mem_ack) ack_cnt <= 0;
        else                     ack_cnt <= ack_cnt + 1;
        if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] data;
        logic [7:0]  target;
        int          delay;
        bit          poke;
        logic [1:0]  err;
        logic [7:0]  addr;
        logic        we;
        logic [15:0] wdata;
        int          ndec;
        int          ninc;
        logic        rsp_v;
        logic [15:0] rsp;
        logic        pc_v;
        logic [7:0]  pc;
        logic [7:0]  sp_after;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(
        input logic [1:0] op, input logic [15:0] data, input logic [7:0] target,
        input int delay, input bit poke, input logic [1:0] err, input logic [7:0] addr,
        input logic we, input logic [15:0] wdata, input int ndec, input int ninc,
        input logic rsp_v, input logic [15:0] rsp, input logic pc_v, input logic [7:0] pc,
        input logic [7:0] sp_after);
        vec_t v;
        v.op = op; v.data = data; v.target = target; v.delay = delay; v.poke = poke;
        v.err = err; v.addr = addr; v.we = we; v.wdata = wdata; v.ndec = ndec;
        v.ninc = ninc; v.rsp_v = rsp_v; v.rsp = rsp; v.pc_v = pc_v; v.pc = pc;
        v.sp_after = sp_after;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command and observe every cycle until the controller is idle again.
    task automatic do_cmd(input vec_t v, input string tag);
        int nreq, ndec, ninc, nrsp, npc, nerr, strobe_k;
        logic [1:0]  err1;
        logic [7:0]  a0, pc_last;
        logic        we0;
        logic [15:0] wd0, rsp_last;
        bit          unstable, done;
        nreq = 0; ndec = 0; ninc = 0; nrsp = 0; npc = 0; nerr = 0; strobe_k = 0;
        err1 = 2'b00; a0 = 8'h00; pc_last = 8'h00; we0 = 1'b0; wd0 = 16'h0;
        rsp_last = 16'h0; unstable = 0; done = 0;
        @(negedge clk);
        chk({tag, " ready"}, cmd_ready, 1);
        cmd_op = v.op; cmd_data = v.data; cmd_target = v.target;
        ack_delay = v.delay; cmd_valid = 1'b1;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            if (k == 1) err1 = stack_err;
            if (stack_err != 2'b00) nerr++;
            if (mem_req) begin
                if (nreq == 0) begin
                    a0 = mem_addr; we0 = mem_we; wd0 = mem_wdata;
                end else if (mem_addr !== a0 || mem_we !== we0 || mem_wdata !== wd0) begin
                    unstable = 1;
                end
                nreq++;
            end
            if (dcr_SP) begin ndec++; strobe_k = k; end
            if (inr_SP) begin ninc++; strobe_k = k; end
            if (rsp_valid) begin nrsp++; rsp_last = rsp_data; end
            if (pc_load_en) begin npc++; pc_last = pc_load; end
            if (k == 1 && !v.poke) cmd_valid = 1'b0;
            if (k == 1 && v.poke) cmd_op = OP_POP;
            if (k == 2) cmd_valid = 1'b0;
            if (cmd_ready) done = 1;
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: controller never returned to idle", tag);
        end
        chk({tag, " err"}, err1, v.err);
        chk({tag, " err_cycles"}, nerr, (v.err != 2'b00) ? 1 : 0);
        chk({tag, " mem_req_cycles"}, nreq, (v.err != 2'b00) ? 0 : v.delay + 1);
        if (v.err == 2'b00) begin
            chk({tag, " addr"}, a0, v.addr);
            chk({tag, " we"}, we0, v.we);
            if (v.we) chk({tag, " wdata"}, wd0, v.wdata);
            chk({tag, " mem_stable"}, unstable, 0);
            chk({tag, " strobe_cycle"}, strobe_k, v.delay + 2);
        end
        chk({tag, " dcr_count"}, ndec, v.ndec);
        chk({tag, " inr_count"}, ninc, v.ninc);
        chk({tag, " rsp_count"}, nrsp, v.rsp_v ? 1 : 0);
        if (v.rsp_v) begin
            chk({tag, " rsp_data"}, rsp_last, v.rsp);
            chk({tag, " rsp_hold"}, rsp_data, v.rsp);
        end
        chk({tag, " pc_count"}, npc, v.pc_v ? 1 : 0);
        if (v.pc_v) chk({tag, " pc_load"}, pc_last, v.pc);
        chk({tag, " sp"}, sp, v.sp_after);
        @(negedge clk);
        chk({tag, " quiet_after"}, {stack_err, inr_SP, dcr_SP, cmd_ready}, 5'b00001);
    endtask

    initial begin
        vec_t v;
        vecs[0] = mk(OP_PUSH, 16'hA5A5, 8'h00, 0, 0, 2'b00, 8'hEF, 1, 16'hA5A5, 1, 0, 0, 16'h0, 0, 8'h00, 8'hEF);
        vecs[1] = mk(OP_POP,  16'h0000, 8'h00, 3, 0, 2'b00, 8'hEF, 0, 16'h0000, 0, 1, 1, 16'hA5A5, 0, 8'h00, 8'hF0);
        vecs[2] = mk(OP_CALL, 16'h1234, 8'h80, 1, 1, 2'b00, 8'hEF, 1, 16'h0034, 1, 0, 0, 16'h0, 1, 8'h80, 8'hEF);
        vecs[3] = mk(OP_RET,  16'h0000, 8'h00, 2, 0, 2'b00, 8'hEF, 0, 16'h0000, 0, 1, 0, 16'h0, 1, 8'h34, 8'hF0);
        vecs[4] = mk(OP_POP,  16'h0000, 8'h00, 0, 0, 2'b10, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0, 0, 8'h00, 8'hF0);
        vecs[5] = mk(OP_RET,  16'h0000, 8'h00, 0, 0, 2'b10, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h0, 0, 8'h00, 8'hF0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset outputs", {mem_req, mem_we, inr_SP, dcr_SP, rsp_valid, pc_load_en, stack_err}, 8'h00);
        chk("reset mem_addr", mem_addr, 8'h00);
        chk("reset mem_wdata", mem_wdata, 16'h0000);
        chk("reset rsp_data", rsp_data, 16'h0000);
        chk("reset pc_load", pc_load, 8'h00);
        reset = 1'b1;
        @(negedge clk);
        chk("ready after release", cmd_ready, 1);
        chk("sp after release", sp, 8'hF0);

        foreach (vecs[i]) do_cmd(vecs[i], $sformatf("vec%0d", i));

        // Acknowledge with no request outstanding must not move the FSM
        @(negedge clk); spur_ack = 1'b1;
        @(negedge clk); spur_ack = 1'b0;
        chk("spur_ack ready", cmd_ready, 1);
        chk("spur_ack strobes", {inr_SP, dcr_SP, rsp_valid, pc_load_en}, 4'b0000);
        @(negedge clk);
        chk("spur_ack sp", sp, 8'hF0);

        // Fill the stack down to the limit
        for (int i = 0; i < 48; i++) begin
            v = mk(OP_PUSH, 16'h1000 + 16'(i), 8'h00, i % 3, 0, 2'b00, 8'hEF - 8'(i), 1,
                   16'h1000 + 16'(i), 1, 0, 0, 16'h0, 0, 8'h00, 8'hEF - 8'(i));
            do_cmd(v, $sformatf("fill%0d", i));
        end
        chk("full sp", sp, 8'hC0);
        v = mk(OP_PUSH, 16'hDEAD, 8'h00, 0, 0, 2'b01, 8'h00, 0, 16'h0, 0, 0, 0, 16'h0, 0, 8'h00, 8'hC0);
        do_cmd(v, "overflow_push");
        v = mk(OP_CALL, 16'h0055, 8'h66, 0, 0, 2'b01, 8'h00, 0, 16'h0, 0, 0, 0, 16'h0, 0, 8'h00, 8'hC0);
        do_cmd(v, "overflow_call");
        v = mk(OP_POP, 16'h0000, 8'h00, 1, 0, 2'b00, 8'hC0, 0, 16'h0, 0, 1, 1, 16'h102F, 0, 8'h00, 8'hC1);
        do_cmd(v, "pop_full");

        // Reset during a withheld transfer
        @(negedge clk);
        cmd_op = OP_PUSH; cmd_data = 16'hBEEF; ack_delay = 1000; cmd_valid = 1'b1;
        @(negedge clk); cmd_valid = 1'b0;
        chk("withheld mem_req", mem_req, 1);
        @(negedge clk);
        chk("withheld mem_req hold", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        chk("async mem_req", mem_req, 0);
        chk("async outputs", {mem_we, inr_SP, dcr_SP, rsp_valid, pc_load_en, stack_err}, 7'h00);
        chk("async mem_addr", mem_addr, 8'h00);
        chk("async mem_wdata", mem_wdata, 16'h0000);
        chk("async rsp_data", rsp_data, 16'h0000);
        chk("async sp", sp, 8'hF0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("post reset ready", cmd_ready, 1);
        chk("post reset strobes", {inr_SP, dcr_SP}, 2'b00);
        chk("post reset sp", sp, 8'hF0);
        v = mk(OP_PUSH, 16'h5A5A, 8'h00, 1, 0, 2'b00, 8'hEF, 1, 16'h5A5A, 1, 0, 0, 16'h0, 0, 8'h00, 8'hEF);
        do_cmd(v, "post_reset_push");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_controller.md
STACK_CONTROLLER -- requirements
Module: stack_controller

Interface
REQ-001 SHALL have parameter STACK_TOP, default 8'hF0, meaning empty-stack SP value.
REQ-002 SHALL have parameter STACK_LIMIT, default 8'hC0, meaning lowest legal SP value (full stack).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  controller idle, can accept a command.
REQ-007 cmd_op  input  2  operation: PUSH=0, POP=1, CALL=2, RET=3.
REQ-008 cmd_data  input  16  PUSH data, or return address for CALL (bits 7:0 used).
REQ-009 cmd_target  input  8  CALL jump target.
REQ-010 SP  input  8  current stack pointer from the stack_pointer block.
REQ-011 inr_SP / dcr_SP  output  1 each  one-cycle increment/decrement strobes to stack_pointer.
REQ-012 mem_req, mem_we  output  1 each  memory request, write enable.
REQ-013 mem_addr  output  8  memory address.
REQ-014 mem_wdata / mem_rdata  output / input  16  memory write / read data.
REQ-015 mem_ack  input  1  memory transfer complete; valid only while mem_req=1.
REQ-016 rsp_valid  output  1  one-cycle pulse: POP result on rsp_data.
REQ-017 rsp_data  output  16  popped word.
REQ-018 pc_load_en  output  1  one-cycle pulse: load PC with pc_load.
REQ-019 pc_load  output  8  new PC value (CALL target or RET popped address).
REQ-020 stack_err  output  2  one-cycle pulse code: 00 none, 01 overflow, 10 underflow.

Function
REQ-021 FSM states IDLE, MEM, UPD; cmd_ready=1 only in IDLE.
REQ-022 Command accepted on edge where cmd_valid & cmd_ready; op, data, target, SP-derived address captured in registers.
REQ-023 PUSH/CALL with SP==STACK_LIMIT: overflow; POP/RET with SP==STACK_TOP: underflow.
REQ-024 On overflow/underflow: stay IDLE, stack_err pulses for the one cycle after accept; no mem_req, no SP strobe, no rsp_valid, no pc_load_en.
REQ-025 Legal command: IDLE -> MEM; mem_req=1 continuously in MEM until mem_ack sampled high; mem_addr, mem_we, mem_wdata held stable throughout.
REQ-026 PUSH/CALL: mem_we=1, mem_addr=SP-1 (8-bit), mem_wdata=cmd_data (CALL: {8'h00, cmd_data[7:0]}).
REQ-027 POP/RET: mem_we=0, mem_addr=SP; mem_rdata captured on the mem_ack cycle.
REQ-028 MEM -> UPD on mem_ack; UPD lasts exactly one cycle, then IDLE.
REQ-029 In UPD: PUSH/CALL assert dcr_SP; POP/RET assert inr_SP; never both.
REQ-030 In UPD: POP asserts rsp_valid with rsp_data=captured word; CALL asserts pc_load_en with pc_load=cmd_target; RET asserts pc_load_en with pc_load=captured word[7:0].
REQ-031 Minimum latency accept-to-strobe: 2 cycles (ack in first MEM cycle); new SP visible in following IDLE cycle, so back-to-back commands see updated SP.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 cmd_valid while not IDLE SHALL be ignored (not queued).
REQ-034 rsp_data and pc_load hold last value between pulses.

Reset
REQ-035 reset=0 asynchronously forces IDLE, all strobes/pulses 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rsp_data=0, pc_load=0, stack_err=00; cmd_ready=1 after release.
REQ-036 Reset mid-MEM abandons the transfer with no SP strobe; stack_pointer concurrently returns to STACK_TOP.

Structure
REQ-037 Shared package stack_pkg holds op encodings, stack_err codes, FSM state encoding, STACK_TOP/STACK_LIMIT defaults.
REQ-038 No sub-module; single FSM plus capture registers; connects directly to stack_pointer.

Verification
REQ-039 Bench instantiates stack_controller with stack_pointer and a memory model with programmable ack delay.
REQ-040 PUSH 16'hA5A5 from reset (SP=F0), ack delay 0 -> write at 8'hEF, dcr_SP pulse 2 cycles after accept, SP=EF.
REQ-041 Then POP, ack delay 3 -> read 8'hEF, rsp_valid with 16'hA5A5, inr_SP pulse, SP=F0.
REQ-042 CALL data=8'h34 target=8'h80, then RET -> pc_load 8'h80 then 8'h34, SP back to F0.
REQ-043 POP at SP=F0 -> stack_err=10 one cycle, no mem_req; 48 PUSHes -> SP=C0, 49th -> stack_err=01, SP unchanged.
REQ-044 Reset asserted during MEM with ack withheld -> mem_req drops immediately, no strobe, SP=F0, cmd_ready=1 after release.
